// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int FETCH_XLEN    = 64;
    localparam int FETCH_INSTRSZ = 32;
    localparam int PC_STEP       = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0]    pc;
        logic [FETCH_INSTRSZ-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry synchronous FIFO of fetched {pc, instr} pairs; flush dominates push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(QDEPTH):0]  count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(QDEPTH);

    fetch_entry_t    store [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(QDEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: PC, one-outstanding memory requests, fetch queue toward decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign output and halts on misaligned PCs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int XLEN    = FETCH_XLEN,
    parameter int INSTRSZ = FETCH_INSTRSZ,
    parameter int QDEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [XLEN-1:0]    entry_pc,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [XLEN-1:0]    mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTRSZ-1:0] mem_resp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTRSZ-1:0] dec_instr,
    output logic [XLEN-1:0]    dec_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic               fetch_misalign,
`endif
    output logic               busy
);

    localparam int CW = $clog2(QDEPTH) + 2;

    fetch_state_e            state, state_nxt;
    logic [XLEN-1:0]         pc, pc_nxt;
    logic [XLEN-1:0]         req_pc;
    logic                    req_fire;
    logic                    outstanding;
    logic                    credit_ok;
    logic                    push, flush, pop;
    logic                    bad_start, bad_redir, halt_q;
    fetch_entry_t            q_wdata, q_rdata;
    logic [$clog2(QDEPTH):0] q_count;
    logic                    q_empty, q_full;

    assign outstanding   = (state == WAIT) || (state == DISCARD);
    assign credit_ok     = !q_full && ((CW'(q_count) + CW'(outstanding)) < CW'(QDEPTH));
    assign mem_req_valid = (state == REQ) && credit_ok;
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign busy          = (state != IDLE);

    assign dec_valid = !q_empty;
    assign pop       = dec_valid && dec_ready;
    // Mask the unreset storage so the decoder sees zeros while the queue is empty.
    assign dec_instr = q_empty ? '0 : q_rdata.instr;
    assign dec_pc    = q_empty ? '0 : q_rdata.pc;

    assign q_wdata.pc    = req_pc;
    assign q_wdata.instr = mem_resp_data;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;
    logic halt_nxt;

    assign bad_start      = (entry_pc[1:0] != 2'b00);
    assign bad_redir      = (redirect_pc[1:0] != 2'b00);
    assign halt_nxt       = (redirect_valid && state != IDLE) ? bad_redir : halt_q;
    assign fetch_misalign = misalign_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            halt_q <= halt_nxt;
            if ((state == IDLE && start && bad_start) ||
                (state != IDLE && redirect_valid && bad_redir))
                misalign_q <= 1'b1;
        end
    end
`else
    assign bad_start = 1'b0;
    assign bad_redir = 1'b0;
    assign halt_q    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_nxt    = entry_pc;
                    state_nxt = bad_start ? IDLE : REQ;
                end
            end
            REQ: begin
                if (req_fire) begin
                    pc_nxt    = pc + XLEN'(PC_STEP);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    push      = 1'b1;
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                if (mem_resp_valid) state_nxt = halt_q ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
        // Redirect overrides everything; a response in this same cycle retires the outstanding request.
        if (redirect_valid && state != IDLE) begin
            flush  = 1'b1;
            push   = 1'b0;
            pc_nxt = redirect_pc;
            if ((state == REQ && req_fire) || (outstanding && !mem_resp_valid))
                state_nxt = DISCARD;
            else
                state_nxt = bad_redir ? IDLE : REQ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) req_pc <= pc;
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (q_wdata),
        .rdata   (q_rdata),
        .count   (q_count),
        .empty   (q_empty),
        .full    (q_full)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level model (queue of fetched words).
module tb_fetch_sequencer;

    localparam int XLEN    = 64;
    localparam int INSTRSZ = 32;
    localparam int QDEPTH  = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [XLEN-1:0]    entry_pc;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_resp_valid;
    logic [INSTRSZ-1:0] mem_resp_data;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTRSZ-1:0] dec_instr;
    logic [XLEN-1:0]    dec_pc;
    logic               busy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic               fetch_misalign;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .XLEN    (XLEN),
        .INSTRSZ (INSTRSZ),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .entry_pc       (entry_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .busy           (busy)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: running flag, one outstanding request, expected decoder stream.
    bit          m_run, m_out, m_live, m_halt, m_mis;
    logic [63:0] m_pc, m_req_pc;
    ent_t        mq[$];

    // Memory model: owes one response per accepted request after a random delay.
    bit          mem_owe;
    logic [63:0] mem_addr;
    int          mem_dly;

    int p_ready, p_dec, dly_lo, dly_hi;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic step(input bit do_start, input logic [63:0] spc,
                        input bit do_redir, input logic [63:0] rpc);
        bit   exp_req, fire, resp, pop;
        ent_t e;
        @(negedge clk);
        exp_req = m_run && !m_out && (mq.size() < QDEPTH);
        check_eq("mem_req_valid", mem_req_valid, exp_req);
        if (exp_req) check_eq("mem_req_addr", mem_req_addr, m_pc);
        check_eq("dec_valid", dec_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("dec_pc", dec_pc, mq[0].pc);
            check_eq("dec_instr", dec_instr, mq[0].instr);
        end
        check_eq("busy", busy, m_run);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("fetch_misalign", fetch_misalign, m_mis);
`endif
        start          = do_start;
        entry_pc       = spc;
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        mem_req_ready  = ($urandom_range(99) < p_ready);
        dec_ready      = ($urandom_range(99) < p_dec);
        resp = 1'b0;
        if (mem_owe) begin
            if (mem_dly == 0) resp = 1'b1;
            else mem_dly--;
        end
        mem_resp_valid = resp;
        mem_resp_data  = resp ? mem_word(mem_addr) : $urandom;
        fire = mem_req_valid && mem_req_ready;
        pop  = dec_valid && dec_ready;

        if (resp) mem_owe = 1'b0;
        if (fire) begin
            mem_owe  = 1'b1;
            mem_addr = mem_req_addr;
            mem_dly  = $urandom_range(dly_hi, dly_lo);
        end

        if (!m_run) begin
            if (do_start) begin
                m_pc = spc;
                if (spc[1:0] != 2'b00 && m_chk_en()) m_mis = 1'b1;
                else m_run = 1'b1;
            end
        end else if (do_redir) begin
            mq.delete();
            m_out  = fire || (m_out && !resp);
            m_live = 1'b0;
            m_pc   = rpc;
            m_halt = 1'b0;
            if (rpc[1:0] != 2'b00 && m_chk_en()) begin
                m_mis = 1'b1;
                if (m_out) m_halt = 1'b1;
                else m_run = 1'b0;
            end
        end else begin
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (resp && m_out) begin
                if (m_live) begin
                    e.pc    = m_req_pc;
                    e.instr = mem_word(m_req_pc);
                    mq.push_back(e);
                end else if (m_halt) begin
                    m_run  = 1'b0;
                    m_halt = 1'b0;
                end
                m_out = 1'b0;
            end
            if (fire) begin
                m_out    = 1'b1;
                m_live   = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 64'd4;
            end
        end
    endtask

    function automatic bit m_chk_en();
`ifdef FETCH_MISALIGN_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        start          = 1'b0;
        entry_pc       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        dec_ready      = 1'b0;
        #1;
        check_eq("rst_mem_req_valid", mem_req_valid, 1'b0);
        check_eq("rst_mem_req_addr", mem_req_addr, 64'h0);
        check_eq("rst_dec_valid", dec_valid, 1'b0);
        check_eq("rst_dec_instr", dec_instr, 32'h0);
        check_eq("rst_dec_pc", dec_pc, 64'h0);
        check_eq("rst_busy", busy, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("rst_fetch_misalign", fetch_misalign, 1'b0);
`endif
        m_run = 0; m_out = 0; m_live = 0; m_halt = 0; m_mis = 0; m_pc = '0;
        mq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_run(input int n);
        logic [63:0] rpc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < 3) begin
                rpc = {$urandom, $urandom} & ~64'h3;
                if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                step(0, '0, 1, rpc);
            end else begin
                step(0, '0, 0, '0);
            end
        end
    endtask

    initial begin
        mem_owe = 0; mem_addr = '0; mem_dly = 0;
        p_ready = 100; p_dec = 100; dly_lo = 0; dly_hi = 0;
        do_reset();

        // Zero-wait fetch from 0x1000 with the decoder always ready.
        step(1, 64'h1000, 0, '0);
        repeat (10) step(0, '0, 0, '0);

        // Decoder stall fills the queue to QDEPTH, then fetching resumes.
        p_dec = 0;
        repeat (20) step(0, '0, 0, '0);
        check_eq("stall_queue_depth", 64'(mq.size()), 64'(QDEPTH));
        p_dec = 100;
        repeat (8) step(0, '0, 0, '0);

        // Redirect while a request is outstanding with a slow response.
        dly_lo = 3; dly_hi = 3;
        for (int i = 0; i < 20 && !m_out; i++) step(0, '0, 0, '0);
        check_eq("sync_wait_outstanding", m_out, 1'b1);
        step(0, '0, 1, 64'h2000);
        repeat (8) step(0, '0, 0, '0);

        // Redirect coincident with a response and a decoder handshake.
        dly_lo = 0; dly_hi = 0; p_dec = 0;
        repeat (7) step(0, '0, 0, '0);
        p_dec = 100;
        for (int i = 0; i < 20 && !(m_out && mem_owe && mem_dly == 0 && mq.size() != 0); i++)
            step(0, '0, 0, '0);
        check_eq("sync_coincident", m_out && mq.size() != 0, 1'b1);
        step(0, '0, 1, 64'h2000);
        check_eq("coincident_no_outstanding", m_out, 1'b0);
        repeat (6) step(0, '0, 0, '0);

        // Memory not ready while a redirect moves the pending request address.
        p_ready = 0;
        for (int i = 0; i < 20 && !(m_run && !m_out); i++) step(0, '0, 0, '0);
        check_eq("sync_req_state", m_run && !m_out, 1'b1);
        step(0, '0, 0, '0);
        step(0, '0, 1, 64'h3000);
        repeat (3) step(0, '0, 0, '0);
        p_ready = 100;
        repeat (6) step(0, '0, 0, '0);

        // Random traffic.
        p_ready = 70; p_dec = 60; dly_lo = 0; dly_hi = 3;
        random_run(1500);

        // Reset mid-operation; stale responses arrive while idle; restart near the PC wrap point.
        do_reset();
        repeat (6) step(0, '0, 0, '0);
        step(1, 64'hFFFF_FFFF_FFFF_FFF0, 0, '0);
        random_run(600);

`ifdef FETCH_MISALIGN_CHECK_EN
        p_ready = 100; p_dec = 100; dly_lo = 2; dly_hi = 2;
        for (int i = 0; i < 20 && !m_out; i++) step(0, '0, 0, '0);
        step(0, '0, 1, 64'h2002);
        repeat (8) step(0, '0, 0, '0);
        check_eq("misalign_idle", busy, 1'b0);
        check_eq("misalign_sticky", fetch_misalign, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
